// File: rtl/ram_pkg.sv
// Shared constants and types for the dual-port synchronous RAM family.
package ram_pkg;

    // Same-address read-during-write behaviour selectors
    localparam int RDW_READ_FIRST  = 0;
    localparam int RDW_WRITE_FIRST = 1;

    // Clear sequencer states: INIT zeroes the array, RUN accepts accesses
    typedef enum logic {
        INIT,
        RUN
    } init_state_t;

endpackage

// File: rtl/ram_init_ctrl.sv
// Clear sequencer: after reset, walks addresses 0..DEPTH-1 writing zero,
// then hands the array over to the user ports.
module ram_init_ctrl
    import ram_pkg::*;
#(
    parameter int ADDR_W         = 5,
    parameter int DEPTH          = 32,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              init_busy,
    output logic              init_we,
    output logic [ADDR_W-1:0] init_addr
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    init_state_t       state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;

    // State and counter registers; reset restarts the sweep from address 0
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= (CLEAR_ON_RESET != 0) ? INIT : RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: leave INIT on the edge that writes the last entry
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        init_busy = 1'b0;
        init_we   = 1'b0;
        case (state_q)
            INIT: begin
                init_busy = 1'b1;
                init_we   = 1'b1;
                cnt_d     = cnt_q + 1'b1;
                if (cnt_q == LAST_ADDR) begin
                    state_d = RUN;
                end
            end
            default: begin
            end
        endcase
    end

    assign init_addr = cnt_q;

endmodule

// File: rtl/ram_dp_sync_init.sv
// Synchronous dual-port RAM: port A read/write, port B read-only, with
// selectable read-during-write behaviour, optional output register and
// zero-fill after reset.
module ram_dp_sync_init
    import ram_pkg::*;
#(
    parameter int DATA_W         = 8,
    parameter int ADDR_W         = 5,
    parameter int DEPTH          = 32,
    parameter int RDW_MODE       = 0,
    parameter int OUT_REG        = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              init_busy,
    input  logic              a_en,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic [DATA_W-1:0] a_rdata,
    output logic              a_rvalid,
    input  logic              b_en,
    input  logic [ADDR_W-1:0] b_addr,
    output logic [DATA_W-1:0] b_rdata,
    output logic              b_rvalid
);

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    logic              init_we;
    logic [ADDR_W-1:0] init_addr;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              a_acc, b_acc, a_in, b_in;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] a_rd, b_rd;

    logic              a_vld_p0, b_vld_p0;
    logic [DATA_W-1:0] a_rdata_p0, b_rdata_p0;

    ram_init_ctrl #(
        .ADDR_W        (ADDR_W),
        .DEPTH         (DEPTH),
        .CLEAR_ON_RESET(CLEAR_ON_RESET)
    ) u_init_ctrl (
        .clk      (clk),
        .rst_n    (rst_n),
        .init_busy(init_busy),
        .init_we  (init_we),
        .init_addr(init_addr)
    );

    // User accesses are only honoured once the clear sweep has finished
    assign a_acc = a_en & ~init_busy;
    assign b_acc = b_en & ~init_busy;
    assign a_in  = {1'b0, a_addr} < DEPTH_L;
    assign b_in  = {1'b0, b_addr} < DEPTH_L;

    // Write port mux: sequencer owns the array while busy, port A otherwise
    always_comb begin
        wr_en   = rst_n & init_we;
        wr_addr = init_addr;
        wr_data = '0;
        if (!init_busy) begin
            wr_en   = rst_n & a_en & a_we & a_in;
            wr_addr = a_addr;
            wr_data = a_wdata;
        end
    end

    // Storage array; out-of-range writes never reach it
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read data with collision bypass; out-of-range reads yield zero
    always_comb begin
        a_rd = '0;
        b_rd = '0;
        if (a_in) begin
            a_rd = (RDW_MODE == RDW_WRITE_FIRST && a_we) ? a_wdata : mem[a_addr];
        end
        if (b_in) begin
            b_rd = (RDW_MODE == RDW_WRITE_FIRST && a_en && a_we && a_addr == b_addr)
                   ? a_wdata : mem[b_addr];
        end
    end

    // Stage p0: registered read result, data held when no read occurs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_vld_p0   <= 1'b0;
            b_vld_p0   <= 1'b0;
            a_rdata_p0 <= '0;
            b_rdata_p0 <= '0;
        end else begin
            a_vld_p0 <= a_acc;
            b_vld_p0 <= b_acc;
            if (a_acc) a_rdata_p0 <= a_rd;
            if (b_acc) b_rdata_p0 <= b_rd;
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic              a_vld_p1, b_vld_p1;
            logic [DATA_W-1:0] a_rdata_p1, b_rdata_p1;

            // Stage p1: extra output register, same hold behaviour as p0
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    a_vld_p1   <= 1'b0;
                    b_vld_p1   <= 1'b0;
                    a_rdata_p1 <= '0;
                    b_rdata_p1 <= '0;
                end else begin
                    a_vld_p1 <= a_vld_p0;
                    b_vld_p1 <= b_vld_p0;
                    if (a_vld_p0) a_rdata_p1 <= a_rdata_p0;
                    if (b_vld_p0) b_rdata_p1 <= b_rdata_p0;
                end
            end

            assign a_rdata  = a_rdata_p1;
            assign a_rvalid = a_vld_p1;
            assign b_rdata  = b_rdata_p1;
            assign b_rvalid = b_vld_p1;
        end else begin : g_no_reg
            assign a_rdata  = a_rdata_p0;
            assign a_rvalid = a_vld_p0;
            assign b_rdata  = b_rdata_p0;
            assign b_rvalid = b_vld_p0;
        end
    endgenerate

endmodule

// File: tb/tb_ram_dp_sync_init.sv
// Bench for ram_dp_sync_init: two instances on shared stimulus.
// dut0: DEPTH=32, read-first, no output register.
// dut1: DEPTH=20, write-first, output register.
module tb_ram_dp_sync_init;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       a_en, a_we, b_en;
    logic [4:0] a_addr, b_addr;
    logic [7:0] a_wdata;

    logic       busy0, busy1, av0, av1, bv0, bv1;
    logic [7:0] ad0, ad1, bd0, bd1;

    ram_dp_sync_init #(
        .DATA_W(8), .ADDR_W(5), .DEPTH(32), .RDW_MODE(0), .OUT_REG(0), .CLEAR_ON_RESET(1)
    ) dut0 (
        .clk(clk), .rst_n(rst_n), .init_busy(busy0),
        .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_rdata(ad0), .a_rvalid(av0),
        .b_en(b_en), .b_addr(b_addr), .b_rdata(bd0), .b_rvalid(bv0)
    );

    ram_dp_sync_init #(
        .DATA_W(8), .ADDR_W(5), .DEPTH(20), .RDW_MODE(1), .OUT_REG(1), .CLEAR_ON_RESET(1)
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .init_busy(busy1),
        .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_rdata(ad1), .a_rvalid(av1),
        .b_en(b_en), .b_addr(b_addr), .b_rdata(bd1), .b_rvalid(bv1)
    );

    // Observed output bundle per instance: {busy, a_rvalid, a_rdata, b_rvalid, b_rdata}
    logic [18:0] obs [2];
    assign obs[0] = {busy0, av0, ad0, bv0, bd0};
    assign obs[1] = {busy1, av1, ad1, bv1, bd1};

    int passed = 0;
    int total  = 0;

    // Reference model state
    int         depth [2] = '{32, 20};
    int         rdw   [2] = '{0, 1};
    int         oreg  [2] = '{0, 1};
    logic [7:0] mem_m [2][32];
    int         init_left [2];
    logic       ea_v [2], eb_v [2], sa_v [2], sb_v [2];
    logic [7:0] ea_d [2], eb_d [2], sa_d [2], sb_d [2];

    function automatic logic [18:0] exp_vec(int i);
        return {(init_left[i] > 0), ea_v[i], ea_d[i], eb_v[i], eb_d[i]};
    endfunction

    // Advance one clock: update the model from the current inputs, then
    // step the clock and stop at the falling edge for sampling/driving.
    task automatic tick();
        logic [7:0] ra, rb;
        logic       acc_a, acc_b;
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                init_left[i] = depth[i];
                ea_v[i] = 0; eb_v[i] = 0; sa_v[i] = 0; sb_v[i] = 0;
                ea_d[i] = 0; eb_d[i] = 0; sa_d[i] = 0; sb_d[i] = 0;
            end else begin
                acc_a = a_en && (init_left[i] == 0);
                acc_b = b_en && (init_left[i] == 0);
                ra = 8'h00;
                rb = 8'h00;
                if (acc_a && a_addr < depth[i])
                    ra = (a_we && rdw[i] == 1) ? a_wdata : mem_m[i][a_addr];
                if (acc_b && b_addr < depth[i])
                    rb = (rdw[i] == 1 && a_en && a_we && a_addr == b_addr) ? a_wdata : mem_m[i][b_addr];
                if (oreg[i] == 1) begin
                    ea_v[i] = sa_v[i]; if (sa_v[i]) ea_d[i] = sa_d[i];
                    eb_v[i] = sb_v[i]; if (sb_v[i]) eb_d[i] = sb_d[i];
                    sa_v[i] = acc_a;   if (acc_a) sa_d[i] = ra;
                    sb_v[i] = acc_b;   if (acc_b) sb_d[i] = rb;
                end else begin
                    ea_v[i] = acc_a;   if (acc_a) ea_d[i] = ra;
                    eb_v[i] = acc_b;   if (acc_b) eb_d[i] = rb;
                end
                if (init_left[i] > 0) begin
                    mem_m[i][depth[i] - init_left[i]] = 8'h00;
                    init_left[i]--;
                end else if (a_en && a_we && a_addr < depth[i]) begin
                    mem_m[i][a_addr] = a_wdata;
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        a_en = 0; a_we = 0; b_en = 0;
    endtask

    task automatic test_reset();
        int n0, n1;
        rst_n = 0; idle(); a_addr = 0; b_addr = 0; a_wdata = 0;
        tick(); tick();
        for (int i = 0; i < 2; i++) begin
            total++;
            if (obs[i] !== 19'h40000)
                $display("FAIL reset_state dut%0d: got %h expected %h", i, obs[i], 19'h40000);
            else passed++;
        end
        rst_n = 1;
        n0 = 0; n1 = 0;
        for (int k = 0; k < 40; k++) begin
            n0 += int'(busy0);
            n1 += int'(busy1);
            for (int i = 0; i < 2; i++) begin
                total++;
                if (obs[i] !== exp_vec(i))
                    $display("FAIL init_cycle dut%0d k=%0d: got %h expected %h", i, k, obs[i], exp_vec(i));
                else passed++;
            end
            if (init_left[0] > 1) begin
                a_en = 1'($urandom); a_we = 1'($urandom); b_en = 1'($urandom);
                a_addr = 5'($urandom); b_addr = 5'($urandom); a_wdata = 8'($urandom);
            end else idle();
            tick();
        end
        total++;
        if (n0 !== 32) $display("FAIL init_len dut0: got %0d expected 32", n0); else passed++;
        total++;
        if (n1 !== 20) $display("FAIL init_len dut1: got %0d expected 20", n1); else passed++;
    endtask

    task automatic test_clear_readback();
        a_en = 0; a_we = 0; b_en = 1;
        for (int a = 0; a < 32; a++) begin
            b_addr = 5'(a);
            tick();
            total++;
            if ({bv0, bd0} !== 9'h100)
                $display("FAIL clear_read dut0 addr=%0d: got %h expected %h", a, {bv0, bd0}, 9'h100);
            else passed++;
            total++;
            if (obs[1] !== exp_vec(1))
                $display("FAIL clear_read dut1 addr=%0d: got %h expected %h", a, obs[1], exp_vec(1));
            else passed++;
        end
        idle(); tick(); tick();
    endtask

    task automatic test_collision();
        a_en = 1; a_we = 1; a_addr = 5; a_wdata = 8'h11; b_en = 0;
        tick(); idle(); tick(); tick();
        a_en = 1; a_we = 1; a_addr = 5; a_wdata = 8'h22; b_en = 1; b_addr = 5;
        tick(); idle();
        total++;
        if ({av0, ad0, bv0, bd0} !== {1'b1, 8'h11, 1'b1, 8'h11})
            $display("FAIL collision_rf dut0: got %h expected %h", {av0, ad0, bv0, bd0}, {1'b1, 8'h11, 1'b1, 8'h11});
        else passed++;
        tick();
        total++;
        if ({av1, ad1, bv1, bd1} !== {1'b1, 8'h22, 1'b1, 8'h22})
            $display("FAIL collision_wf dut1: got %h expected %h", {av1, ad1, bv1, bd1}, {1'b1, 8'h22, 1'b1, 8'h22});
        else passed++;
        b_en = 1; b_addr = 5;
        tick(); idle();
        total++;
        if ({bv0, bd0} !== {1'b1, 8'h22})
            $display("FAIL after_write dut0: got %h expected %h", {bv0, bd0}, {1'b1, 8'h22});
        else passed++;
        tick();
        for (int i = 0; i < 2; i++) begin
            total++;
            if (obs[i] !== exp_vec(i))
                $display("FAIL after_write_model dut%0d: got %h expected %h", i, obs[i], exp_vec(i));
            else passed++;
        end
    endtask

    task automatic test_out_reg();
        int pulses;
        a_en = 1; a_we = 1; a_addr = 3; a_wdata = 8'h3C;
        tick(); idle(); tick(); tick();
        b_en = 1; b_addr = 3;
        tick(); idle();
        total++;
        if (bv1 !== 1'b0) $display("FAIL oreg_early dut1: got %b expected 0", bv1); else passed++;
        tick();
        total++;
        if ({bv1, bd1} !== {1'b1, 8'h3C})
            $display("FAIL oreg_data dut1: got %h expected %h", {bv1, bd1}, {1'b1, 8'h3C});
        else passed++;
        tick();
        pulses = 0;
        for (int k = 0; k < 6; k++) begin
            if (k < 4) begin b_en = 1; b_addr = 5'(k); end else b_en = 0;
            tick();
            pulses += int'(bv1);
            for (int i = 0; i < 2; i++) begin
                total++;
                if (obs[i] !== exp_vec(i))
                    $display("FAIL b2b dut%0d k=%0d: got %h expected %h", i, k, obs[i], exp_vec(i));
                else passed++;
            end
        end
        total++;
        if (pulses !== 4) $display("FAIL b2b_pulses dut1: got %0d expected 4", pulses); else passed++;
    endtask

    task automatic test_out_of_range();
        a_en = 1; a_we = 1; a_addr = 25; a_wdata = 8'hFF;
        tick(); idle();
        b_en = 1; b_addr = 25;
        tick(); idle();
        total++;
        if ({bv0, bd0} !== {1'b1, 8'hFF})
            $display("FAIL inrange_25 dut0: got %h expected %h", {bv0, bd0}, {1'b1, 8'hFF});
        else passed++;
        tick();
        total++;
        if ({bv1, bd1} !== {1'b1, 8'h00})
            $display("FAIL oor_read dut1: got %h expected %h", {bv1, bd1}, {1'b1, 8'h00});
        else passed++;
        for (int a = 0; a < 22; a++) begin
            if (a < 20) begin b_en = 1; b_addr = 5'(a); end else b_en = 0;
            tick();
            for (int i = 0; i < 2; i++) begin
                total++;
                if (obs[i] !== exp_vec(i))
                    $display("FAIL oor_scan dut%0d a=%0d: got %h expected %h", i, a, obs[i], exp_vec(i));
                else passed++;
            end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            a_en = 1'($urandom); a_we = 1'($urandom); b_en = 1'($urandom);
            a_addr = 5'($urandom); a_wdata = 8'($urandom);
            b_addr = ($urandom_range(0, 3) == 0) ? a_addr : 5'($urandom);
            tick();
            for (int i = 0; i < 2; i++) begin
                total++;
                if (obs[i] !== exp_vec(i))
                    $display("FAIL random dut%0d k=%0d: got %h expected %h", i, k, obs[i], exp_vec(i));
                else passed++;
            end
        end
        idle(); tick(); tick();
    endtask

    task automatic test_mid_reset();
        int n0, n1;
        rst_n = 0; idle(); tick(); rst_n = 1;
        for (int k = 0; k < 10; k++) tick();
        rst_n = 0; tick(); rst_n = 1;
        for (int i = 0; i < 2; i++) begin
            total++;
            if (obs[i] !== 19'h40000)
                $display("FAIL mid_reset dut%0d: got %h expected %h", i, obs[i], 19'h40000);
            else passed++;
        end
        n0 = 0; n1 = 0;
        for (int k = 0; k < 40; k++) begin
            n0 += int'(busy0);
            n1 += int'(busy1);
            tick();
        end
        total++;
        if (n0 !== 32) $display("FAIL restart_len dut0: got %0d expected 32", n0); else passed++;
        total++;
        if (n1 !== 20) $display("FAIL restart_len dut1: got %0d expected 20", n1); else passed++;
        b_en = 1;
        for (int a = 0; a < 33; a++) begin
            if (a < 32) b_addr = 5'(a); else b_en = 0;
            tick();
            for (int i = 0; i < 2; i++) begin
                total++;
                if (obs[i] !== exp_vec(i))
                    $display("FAIL restart_scan dut%0d a=%0d: got %h expected %h", i, a, obs[i], exp_vec(i));
                else passed++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_clear_readback();
        test_collision();
        test_out_reg();
        test_out_of_range();
        test_random();
        test_mid_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
